tx_rec_sched: RTL and testbench

Record-level scheduler and bus arbiter for the 8-bit serial transmitter (Tx8Bits). Two requesters each submit a record of up to `MAX_BYTES` bytes. The block grants the transmitter to one requester at a time (round-robin) and sends the record byte-by-byte in ASCII or hex-BCD form, with an optional trailing CR/LF. It then acknowledges completion. A watchdog aborts a record if the transmitter stops answering.

---
 rtl/tx_pkg.sv | 22 ++
 rtl/tx_rec_sched_if.sv | 36 +++
 rtl/rr_arb2.sv | 22 ++
 rtl/tx_rec_sched.sv | 171 +++++++++++++++++
 tb/tb_tx_rec_sched.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/tx_pkg.sv
// Shared types and constants for the record scheduler.
package tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_START,
    S_WAIT,
    S_ACK,
    S_ERR
  } state_t;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  typedef logic req_idx_t;

  function automatic logic [1:0] idx_onehot(req_idx_t i);
    return i ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tx_rec_sched_if.sv
// Requester and transmitter signals of the record scheduler.
interface tx_rec_sched_if #(
  parameter int MAX_BYTES = 4
);
  localparam int LEN_W = $clog2(MAX_BYTES + 1);

  logic [1:0]             req;
  logic [8*MAX_BYTES-1:0] rec_data0;
  logic [8*MAX_BYTES-1:0] rec_data1;
  logic [LEN_W-1:0]       rec_len0;
  logic [LEN_W-1:0]       rec_len1;
  logic [1:0]             rec_bcd;
  logic [1:0]             rec_crlf;
  logic [1:0]             ack;
  logic [1:0]             err;
  logic                   tx_en;
  logic                   tx_start;
  logic                   tx_BCD;
  logic                   tx_CRLF;
  logic [7:0]             in_data;
  logic                   tx_done;
  logic                   busy;

  // Scheduler side
  modport slave (
    input  req, rec_data0, rec_data1, rec_len0, rec_len1, rec_bcd, rec_crlf, tx_done,
    output ack, err, tx_en, tx_start, tx_BCD, tx_CRLF, in_data, busy
  );

  // Requesters plus transmitter side
  modport master (
    output req, rec_data0, rec_data1, rec_len0, rec_len1, rec_bcd, rec_crlf, tx_done,
    input  ack, err, tx_en, tx_start, tx_BCD, tx_CRLF, in_data, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; rr_ptr only matters when both request.
module rr_arb2
  import tx_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_idx_t   rr_ptr_i,
  output logic [1:0] grant_o,
  output req_idx_t   winner_o
);

  // Pick the winner and derive its one-hot grant
  always_comb begin
    winner_o = 1'b0;
    case (req_i)
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = rr_ptr_i;
      default: winner_o = 1'b0;
    endcase
    grant_o = (req_i == 2'b00) ? 2'b00 : idx_onehot(winner_o);
  end

endmodule

// File: rtl/tx_rec_sched.sv
// Record scheduler: arbitrates two requesters onto the 8-bit transmitter
// and sends one record byte-by-byte with optional CR/LF and a watchdog.
//
// state   | meaning
// IDLE    | bus free, waiting for a request
// LATCH   | capture winner's record, bus enabled
// START   | one-cycle tx_start strobe
// WAIT    | waiting for tx_done, watchdog running
// ACK     | record complete, ack pulse
// ERR     | watchdog expired, err pulse
module tx_rec_sched
  import tx_pkg::*;
#(
  parameter int MAX_BYTES = 4,
  parameter int TIMEOUT   = 4096
) (
  input logic           clk,
  input logic           rst,
  tx_rec_sched_if.slave bus
);

  localparam int LEN_W  = $clog2(MAX_BYTES + 1);
  localparam int IDX_W  = $clog2(MAX_BYTES);
  localparam int WD_W   = $clog2(TIMEOUT);
  localparam int DATA_W = 8 * MAX_BYTES;

  state_t             state_q;
  req_idx_t           rr_ptr_q, win_q;
  logic [DATA_W-1:0]  data_q;
  logic [LEN_W-1:0]   len_q;
  logic               bcd_q, crlf_q, crlf_ph_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WD_W-1:0]    wd_q;
  logic [1:0]         ack_q, err_q;
  logic               tx_en_q, tx_start_q, tx_bcd_q, tx_crlf_q, busy_q;
  logic [7:0]         in_data_q;

  logic [1:0]         grant;
  req_idx_t           winner;
  logic [DATA_W-1:0]  sel_data;
  logic [LEN_W-1:0]   sel_len;
  logic               sel_bcd, sel_crlf;
  logic [IDX_W-1:0]   idx_d;
  logic [7:0]         next_byte;
  logic               more_bytes, wd_max;

  rr_arb2 u_arb (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (grant),
    .winner_o (winner)
  );

  // Winner's live inputs; only sampled during LATCH
  assign sel_data = win_q ? bus.rec_data1 : bus.rec_data0;
  assign sel_len  = win_q ? bus.rec_len1  : bus.rec_len0;
  assign sel_bcd  = bus.rec_bcd[win_q];
  assign sel_crlf = bus.rec_crlf[win_q];

  assign idx_d      = idx_q + IDX_W'(1);
  assign next_byte  = data_q[{idx_d, 3'b000} +: 8];
  assign more_bytes = (LEN_W'(idx_q) + LEN_W'(1)) < len_q;
  assign wd_max     = (wd_q == WD_W'(TIMEOUT - 1));

  // Scheduler FSM with registered outputs for the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= 1'b0;
      win_q      <= 1'b0;
      data_q     <= '0;
      len_q      <= '0;
      bcd_q      <= 1'b0;
      crlf_q     <= 1'b0;
      crlf_ph_q  <= 1'b0;
      idx_q      <= '0;
      wd_q       <= '0;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
      tx_en_q    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_bcd_q   <= 1'b0;
      tx_crlf_q  <= 1'b0;
      in_data_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
      if (!wd_max) wd_q <= wd_q + WD_W'(1);

      case (state_q)
        S_IDLE: begin
          if (|grant) begin
            win_q   <= winner;
            idx_q   <= '0;
            tx_en_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_LATCH;
          end
        end
        S_LATCH: begin
          data_q <= sel_data;
          len_q  <= sel_len;
          bcd_q  <= sel_bcd;
          crlf_q <= sel_crlf;
          if (sel_len == '0 && !sel_crlf) begin
            ack_q   <= idx_onehot(win_q);
            tx_en_q <= 1'b0;
            state_q <= S_ACK;
          end else begin
            crlf_ph_q  <= (sel_len == '0);
            in_data_q  <= (sel_len == '0) ? 8'h00 : sel_data[7:0];
            tx_bcd_q   <= (sel_len == '0) ? 1'b0 : sel_bcd;
            tx_crlf_q  <= (sel_len == '0);
            tx_start_q <= 1'b1;
            wd_q       <= '0;
            state_q    <= S_START;
          end
        end
        S_START: state_q <= S_WAIT;
        S_WAIT: begin
          if (bus.tx_done) begin
            if (!crlf_ph_q && more_bytes) begin
              idx_q      <= idx_d;
              in_data_q  <= next_byte;
              tx_bcd_q   <= bcd_q;
              tx_crlf_q  <= 1'b0;
              tx_start_q <= 1'b1;
              wd_q       <= '0;
              state_q    <= S_START;
            end else if (!crlf_ph_q && crlf_q) begin
              crlf_ph_q  <= 1'b1;
              in_data_q  <= 8'h00;
              tx_bcd_q   <= 1'b0;
              tx_crlf_q  <= 1'b1;
              tx_start_q <= 1'b1;
              wd_q       <= '0;
              state_q    <= S_START;
            end else begin
              ack_q   <= idx_onehot(win_q);
              tx_en_q <= 1'b0;
              state_q <= S_ACK;
            end
          end else if (wd_max) begin
            err_q   <= idx_onehot(win_q);
            tx_en_q <= 1'b0;
            state_q <= S_ERR;
          end
        end
        S_ACK, S_ERR: begin
          rr_ptr_q <= ~win_q;
          tx_en_q  <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.tx_en    = tx_en_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_BCD   = tx_bcd_q;
  assign bus.tx_CRLF  = tx_crlf_q;
  assign bus.in_data  = in_data_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_tx_rec_sched.sv
// Directed bench for tx_rec_sched: normal records, BCD/CRLF, arbitration,
// empty records, watchdog abort and mid-record reset.
module tb_tx_rec_sched;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   en_low;
  int   extra_start;
  int   k;
  int   bad;

  always #5 clk = ~clk;

  tx_rec_sched_if #(.MAX_BYTES(4)) b  ();
  tx_rec_sched_if #(.MAX_BYTES(4)) b2 ();

  tx_rec_sched #(.MAX_BYTES(4), .TIMEOUT(4096)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  tx_rec_sched #(.MAX_BYTES(4), .TIMEOUT(16)) dut_wd (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Answer tx_done so the next start lands n cycles after the current one
  task automatic xmit(input int n);
    for (int i = 0; i < n - 1; i++) begin
      tick();
      if (b.tx_en !== 1'b1) en_low++;
      if (b.tx_start !== 1'b0) extra_start++;
    end
    b.tx_done = 1'b1;
    tick();
    b.tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    b.req = 2'b00;  b.rec_data0 = '0; b.rec_data1 = '0; b.rec_len0 = '0; b.rec_len1 = '0;
    b.rec_bcd = 2'b00; b.rec_crlf = 2'b00; b.tx_done = 1'b0;
    b2.req = 2'b00; b2.rec_data0 = '0; b2.rec_data1 = '0; b2.rec_len0 = '0; b2.rec_len1 = '0;
    b2.rec_bcd = 2'b00; b2.rec_crlf = 2'b00; b2.tx_done = 1'b0;
    en_low = 0; extra_start = 0;

    // Reset state
    tick(); tick();
    chk("rst_tx_en", 32'(b.tx_en), 32'd0);
    chk("rst_busy", 32'(b.busy), 32'd0);
    chk("rst_ack_err", {28'd0, b.ack, b.err}, 32'd0);
    chk("rst_start", 32'(b.tx_start), 32'd0);
    chk("rst_in_data", 32'(b.in_data), 32'd0);
    rst = 1'b0;

    // Req0, two ASCII bytes
    b.rec_data0 = 32'h0000_4241; b.rec_len0 = 3'd2; b.req = 2'b01;
    tick();
    chk("t1_latch_en", 32'(b.tx_en), 32'd1);
    chk("t1_latch_busy", 32'(b.busy), 32'd1);
    chk("t1_latch_nostart", 32'(b.tx_start), 32'd0);
    tick();
    chk("t1_start0", 32'(b.tx_start), 32'd1);
    chk("t1_byte0", 32'(b.in_data), 32'h41);
    chk("t1_bcd0", 32'(b.tx_BCD), 32'd0);
    xmit(20);
    chk("t1_start1", 32'(b.tx_start), 32'd1);
    chk("t1_byte1", 32'(b.in_data), 32'h42);
    xmit(20);
    chk("t1_ack", 32'(b.ack), 32'h1);
    chk("t1_en_held", 32'(en_low), 32'd0);
    b.req = 2'b00;
    tick();
    chk("t1_en_after", 32'(b.tx_en), 32'd0);
    chk("t1_ack_pulse", 32'(b.ack), 32'd0);

    // Req1, one byte in BCD with CR/LF; inputs changed after capture
    b.rec_data1 = 32'h0000_003C; b.rec_len1 = 3'd1; b.rec_bcd = 2'b10; b.rec_crlf = 2'b10;
    b.req = 2'b10;
    tick(); tick();
    chk("t2_start0", 32'(b.tx_start), 32'd1);
    chk("t2_bcd", 32'(b.tx_BCD), 32'd1);
    chk("t2_byte", 32'(b.in_data), 32'h3C);
    chk("t2_crlf0", 32'(b.tx_CRLF), 32'd0);
    b.rec_data1 = 32'hFFFF_FFFF; b.rec_bcd = 2'b00; b.rec_crlf = 2'b00;
    xmit(20);
    chk("t2_start1", 32'(b.tx_start), 32'd1);
    chk("t2_crlf1", 32'(b.tx_CRLF), 32'd1);
    chk("t2_crlf_bcd", 32'(b.tx_BCD), 32'd0);
    chk("t2_crlf_data", 32'(b.in_data), 32'h00);
    xmit(20);
    chk("t2_ack", 32'(b.ack), 32'h2);

    // Both requesting: pointer is 0 now, so req0 then req1 then req0
    b.rec_data0 = 32'h55; b.rec_len0 = 3'd1; b.rec_data1 = 32'h66; b.rec_len1 = 3'd1;
    b.req = 2'b11;
    tick();
    chk("t3_idle_busy", 32'(b.busy), 32'd0);
    tick(); tick();
    chk("t3_first", 32'(b.in_data), 32'h55);
    xmit(5);
    chk("t3_ack0", 32'(b.ack), 32'h1);
    tick(); tick(); tick();
    chk("t3_second_start", 32'(b.tx_start), 32'd1);
    chk("t3_second", 32'(b.in_data), 32'h66);
    xmit(5);
    chk("t3_ack1", 32'(b.ack), 32'h2);
    tick(); tick(); tick();
    chk("t3_third", 32'(b.in_data), 32'h55);
    b.req = 2'b00;
    xmit(5);
    chk("t3_ack_after_drop", 32'(b.ack), 32'h1);

    // Empty record without CR/LF
    b.rec_len0 = 3'd0; b.rec_crlf = 2'b00; b.req = 2'b01;
    tick(); tick();
    chk("t4_latch_nostart", 32'(b.tx_start), 32'd0);
    tick();
    chk("t4_ack", 32'(b.ack), 32'h1);
    chk("t4_nostart", 32'(b.tx_start), 32'd0);
    b.req = 2'b00;

    // Empty record with CR/LF: one strobe only
    b.rec_crlf = 2'b01; b.req = 2'b01;
    tick(); tick(); tick();
    chk("t5_start", 32'(b.tx_start), 32'd1);
    chk("t5_crlf", 32'(b.tx_CRLF), 32'd1);
    chk("t5_data", 32'(b.in_data), 32'h00);
    b.req = 2'b00;
    extra_start = 0;
    xmit(4);
    chk("t5_ack", 32'(b.ack), 32'h1);
    chk("t5_single_start", 32'(extra_start), 32'd0);

    // Reset while waiting for tx_done
    b.rec_data0 = 32'h0000_4241; b.rec_len0 = 3'd2; b.rec_crlf = 2'b00; b.req = 2'b01;
    tick(); tick(); tick(); tick(); tick();
    chk("t7_pre_busy", 32'(b.busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("t7_en", 32'(b.tx_en), 32'd0);
    chk("t7_busy", 32'(b.busy), 32'd0);
    chk("t7_data", 32'(b.in_data), 32'd0);
    chk("t7_start", {31'd0, b.tx_start}, 32'd0);
    rst = 1'b0; b.req = 2'b00;
    b.tx_done = 1'b1;
    tick();
    b.tx_done = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (b.ack !== 2'b00 || b.busy !== 1'b0) bad++;
    end
    chk("t7_late_done_ignored", 32'(bad), 32'd0);

    // Watchdog abort on the TIMEOUT=16 instance
    b2.rec_data0 = 32'h77; b2.rec_len0 = 3'd1; b2.req = 2'b01;
    tick(); tick();
    chk("t6_start", 32'(b2.tx_start), 32'd1);
    k = 0;
    do begin
      tick();
      k++;
    end while (b2.err === 2'b00 && k < 40);
    chk("t6_err", 32'(b2.err), 32'h1);
    chk("t6_err_delay", 32'(k), 32'd16);
    chk("t6_no_ack", 32'(b2.ack), 32'h0);
    b2.req = 2'b00;
    tick();
    chk("t6_en_low", 32'(b2.tx_en), 32'd0);
    b2.rec_data0 = 32'h78; b2.req = 2'b01;
    tick(); tick();
    chk("t6_next_start", 32'(b2.tx_start), 32'd1);
    chk("t6_next_data", 32'(b2.in_data), 32'h78);
    b2.req = 2'b00;
    tick(); tick(); tick();
    b2.tx_done = 1'b1;
    tick();
    b2.tx_done = 1'b0;
    chk("t6_next_ack", 32'(b2.ack), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
